// File: rtl/alu_seq.sv
// alu_seq: handshake ALU with single-cycle ops and N-cycle shift-add MUL / restoring DIV/MOD.
// Define ALU_SEQ_DIV_EN to build the divider; otherwise DIV/MOD finish at once with div_by_zero=1.
module alu_seq #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [5:0]   op,
   input  logic         cin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out,
   output logic         cout,
   output logic         overflow,
   output logic         sign,
   output logic         zero,
   output logic         div_by_zero
);
   localparam int LW = $clog2(N);
   localparam logic [N-1:0] MINV = {1'b1, {(N-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   typedef enum logic [1:0] {K_MUL, K_DIV, K_MOD} kind_t;

   state_t        r_state, w_state_n;
   kind_t         r_kind, w_kind;
   logic [LW-1:0] r_cnt;
   logic [N-1:0]  r_hi, r_lo, r_m;
   logic          r_sgn, r_nq;
   logic [N-1:0]  r_out;
   logic          r_cout, r_ovf, r_sign, r_zero, r_dbz;

   logic          w_acc, w_iter, w_last, w_mul;
   logic          w_sa, w_sb;
   logic [N-1:0]  w_ma, w_mb;
`ifdef ALU_SEQ_DIV_EN
   logic [N-1:0]  r_a, r_b;
   logic          r_nr;
   logic          w_div, w_mod, w_ge;
   logic [N:0]    w_rs;
   logic [N-1:0]  w_rd;
`endif

   // single-cycle datapath
   logic [N-1:0]  w_res, w_lg, w_bx, w_asr, w_ror, w_rol;
   logic [N:0]    w_sum;
   logic [LW-1:0] w_sh;
   logic          w_big, w_cout, w_ovf, w_dbz, w_def;

   // iterative datapath
   logic [N:0]     w_t;
   logic [N-1:0]   w_hi_n, w_lo_n, w_fres;
   logic [2*N-1:0] w_p, w_ps;
   logic           w_fovf, w_fdbz;

   assign in_ready    = (r_state == IDLE);
   assign out_valid   = (r_state == DONE);
   assign out         = r_out;
   assign cout        = r_cout;
   assign overflow    = r_ovf;
   assign sign        = r_sign;
   assign zero        = r_zero;
   assign div_by_zero = r_dbz;

   assign w_acc  = in_valid & (r_state == IDLE);
   assign w_last = &r_cnt;
   assign w_mul  = ~op[5] & (op[3:0] == 4'hA);
   assign w_sa   = op[4] & a[N-1];
   assign w_sb   = op[4] & b[N-1];
   assign w_ma   = w_sa ? -a : a;
   assign w_mb   = w_sb ? -b : b;
`ifdef ALU_SEQ_DIV_EN
   assign w_div  = ~op[5] & (op[3:0] == 4'hB);
   assign w_mod  = ~op[5] & (op[3:0] == 4'hC);
   assign w_iter = w_mul | w_div | w_mod;
   assign w_kind = w_mul ? K_MUL : (w_div ? K_DIV : K_MOD);
`else
   assign w_iter = w_mul;
   assign w_kind = K_MUL;
`endif

   always_comb begin
      w_res  = '0;
      w_lg   = '0;
      w_cout = 1'b0;
      w_ovf  = 1'b0;
      w_dbz  = 1'b0;
      w_def  = 1'b1;
      w_bx   = (op[3:0] == 4'h5) ? ~b : b;
      w_sum  = {1'b0, a} + {1'b0, w_bx} + {{N{1'b0}}, cin};
      w_big  = |b[N-1:LW];
      w_sh   = b[LW-1:0];
      w_asr  = $signed(a) >>> w_sh;
      w_ror  = N'({a, a} >> w_sh);
      w_rol  = N'(({a, a} << w_sh) >> N);
      if (op[3:0] <= 4'h3) begin
         // logic ops: bit5 inverts b before the op, bit4 inverts the result
         case (op[1:0])
            2'd0:    w_lg = a;
            2'd1:    w_lg = a & (op[5] ? ~b : b);
            2'd2:    w_lg = a | (op[5] ? ~b : b);
            default: w_lg = a ^ (op[5] ? ~b : b);
         endcase
         w_res = op[4] ? ~w_lg : w_lg;
      end else if (op[5]) begin
         w_def = 1'b0;
      end else begin
         case (op[4:0])
            5'h04, 5'h14, 5'h05, 5'h15: begin
               w_res  = w_sum[N-1:0];
               w_cout = w_sum[N];
               w_ovf  = (a[N-1] == w_bx[N-1]) && (w_sum[N-1] != a[N-1]);
            end
            5'h06: w_res = w_big ? '0 : a >> w_sh;
            5'h16: w_res = w_big ? {N{a[N-1]}} : w_asr;
            5'h07: w_res = w_big ? '0 : a << w_sh;
            5'h18: w_res = w_ror;
            5'h09: w_res = w_rol;
            5'h0D: w_res = ~a;
            5'h0B, 5'h1B, 5'h0C, 5'h1C: w_dbz = 1'b1;
            default: w_def = 1'b0;
         endcase
      end
   end

   always_comb begin
      w_t    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
      w_hi_n = w_t[N:1];
      w_lo_n = {w_t[0], r_lo[N-1:1]};
`ifdef ALU_SEQ_DIV_EN
      w_rs = {r_hi, r_lo[N-1]};
      w_ge = (w_rs >= {1'b0, r_m});
      w_rd = w_ge ? (w_rs[N-1:0] - r_m) : w_rs[N-1:0];
      if (r_kind != K_MUL) begin
         w_hi_n = w_rd;
         w_lo_n = {r_lo[N-2:0], w_ge};
      end
`endif
   end

   // result and sign fix-up applied on the last BUSY cycle
   always_comb begin
      w_fres = '0;
      w_fovf = 1'b0;
      w_fdbz = 1'b0;
      w_p    = {w_hi_n, w_lo_n};
      w_ps   = r_nq ? -w_p : w_p;
      if (r_kind == K_MUL) begin
         w_fres = w_ps[N-1:0];
         w_fovf = r_sgn ? (w_ps[2*N-1:N] != {N{w_ps[N-1]}}) : (w_ps[2*N-1:N] != '0);
      end
`ifdef ALU_SEQ_DIV_EN
      else if (r_b == '0) begin
         w_fres = (r_kind == K_DIV) ? '1 : r_a;
         w_fdbz = 1'b1;
      end else begin
         w_fovf = r_sgn & (r_a == MINV) & (r_b == '1);
         w_fres = (r_kind == K_DIV) ? (r_nq ? -w_lo_n : w_lo_n) : (r_nr ? -w_hi_n : w_hi_n);
      end
`endif
   end

   always_comb begin
      w_state_n = r_state;
      case (r_state)
         IDLE:    if (in_valid) w_state_n = w_iter ? BUSY : DONE;
         BUSY:    if (w_last) w_state_n = DONE;
         DONE:    if (out_ready) w_state_n = IDLE;
         default: w_state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_out   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_sign  <= 1'b0;
         r_zero  <= 1'b0;
         r_dbz   <= 1'b0;
      end else begin
         r_state <= w_state_n;
         if (w_acc && !w_iter) begin
            r_out  <= w_res;
            r_cout <= w_cout;
            r_ovf  <= w_ovf;
            r_dbz  <= w_dbz;
            r_sign <= w_def & w_res[N-1];
            r_zero <= w_def & (w_res == '0);
         end
         if (r_state == BUSY) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
               r_out  <= w_fres;
               r_cout <= 1'b0;
               r_ovf  <= w_fovf;
               r_dbz  <= w_fdbz;
               r_sign <= w_fres[N-1];
               r_zero <= (w_fres == '0);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_acc) begin
         r_kind <= w_kind;
         r_sgn  <= op[4];
         r_nq   <= w_sa ^ w_sb;
         r_hi   <= '0;
         r_lo   <= (w_kind == K_MUL) ? w_mb : w_ma;
         r_m    <= (w_kind == K_MUL) ? w_ma : w_mb;
`ifdef ALU_SEQ_DIV_EN
         r_a    <= a;
         r_b    <= b;
         r_nr   <= w_sa;
`endif
      end else if (r_state == BUSY) begin
         r_hi <= w_hi_n;
         r_lo <= w_lo_n;
      end
   end
endmodule
